// File: rtl/addr_mode_sequencer_pkg.sv
// Shared definitions for the operand-fetch / effective-address sequencer:
// addressing-mode codes, arithmetic-unit opcodes and the sequencer states.
package addr_mode_sequencer_pkg;

    // 3-bit addressing-mode encoding presented on the mode input.
    localparam logic [2:0] MODE_ZP   = 3'd0;
    localparam logic [2:0] MODE_ZPX  = 3'd1;
    localparam logic [2:0] MODE_ZPY  = 3'd2;
    localparam logic [2:0] MODE_ABS  = 3'd3;
    localparam logic [2:0] MODE_ABSX = 3'd4;
    localparam logic [2:0] MODE_ABSY = 3'd5;
    localparam logic [2:0] MODE_INDX = 3'd6;
    localparam logic [2:0] MODE_INDY = 3'd7;

    // Arithmetic-unit opcodes. The sequencer only ever issues ADR0/ADR1;
    // ADC and LD belong to the execute path that shares the same unit.
    localparam logic [1:0] ALU_ADR0 = 2'b00;
    localparam logic [1:0] ALU_ADR1 = 2'b01;
    localparam logic [1:0] ALU_ADC  = 2'b10;
    localparam logic [1:0] ALU_LD   = 2'b11;

    // Sequencer states.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH_LO = 3'd1,
        S_FETCH_HI = 3'd2,
        S_INDEX_LO = 3'd3,
        S_INDEX_HI = 3'd4,
        S_PTR_LO   = 3'd5,
        S_PTR_HI   = 3'd6,
        S_DONE     = 3'd7
    } seq_state_t;

    // Absolute modes carry a two-byte operand.
    function automatic logic is_abs_mode(input logic [2:0] m);
        return (m == MODE_ABS) || (m == MODE_ABSX) || (m == MODE_ABSY);
    endfunction

    // Modes whose low-byte add may carry into the high byte (page cross).
    function automatic logic uses_carry(input logic [2:0] m);
        return (m == MODE_ABSX) || (m == MODE_ABSY) || (m == MODE_INDY);
    endfunction

    // Modes indexed by X; every other indexed mode uses Y.
    function automatic logic index_uses_x(input logic [2:0] m);
        return (m == MODE_ZPX) || (m == MODE_ABSX) || (m == MODE_INDX);
    endfunction

endpackage

// File: rtl/addr_mode_sequencer_if.sv
// Bus bundle between the execute control (master) and the address sequencer
// (slave): request, memory read port, borrowed arithmetic unit and result.
//
// Handshake: a request is presented by holding start=1 with mode/pc/x/y
// stable; it is taken on the rising edge where busy=0. While busy=1, start
// is ignored (never queued). Completion is a single-cycle ea_valid pulse
// carrying ea/page_cross/oper_len; there is no back-pressure on the result,
// and busy falls on the edge that ends the ea_valid cycle.
interface addr_mode_sequencer_if;
    import addr_mode_sequencer_pkg::*;

    // Request
    logic        start;
    logic [2:0]  mode;
    logic [15:0] pc;
    logic [7:0]  x;
    logic [7:0]  y;
    // Memory read port
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    // Borrowed arithmetic unit
    logic        alu_sel;
    logic [1:0]  alu_opcode;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_out;
    logic        alu_carry;
    // Result
    logic [15:0] ea;
    logic        ea_valid;
    logic        page_cross;
    logic [1:0]  oper_len;
    logic        busy;

    modport master (
        output start, mode, pc, x, y, mem_data, alu_out, alu_carry,
        input  mem_rd, mem_addr, alu_sel, alu_opcode, alu_a, alu_b,
               ea, ea_valid, page_cross, oper_len, busy
    );

    modport slave (
        input  start, mode, pc, x, y, mem_data, alu_out, alu_carry,
        output mem_rd, mem_addr, alu_sel, alu_opcode, alu_a, alu_b,
               ea, ea_valid, page_cross, oper_len, busy
    );

endinterface

// File: rtl/addr_mode_sequencer.sv
// Operand-fetch and effective-address sequencer for the 6502 addressing
// modes zp, zp,X, zp,Y, abs, abs,X, abs,Y, (zp,X) and (zp),Y. Fetches operand
// and pointer bytes, borrows the arithmetic unit for indexing (ADR0 low
// byte, ADR1 high byte plus carry) and reports a 16-bit effective address.
module addr_mode_sequencer
    import addr_mode_sequencer_pkg::*;
#(
    parameter logic [7:0] ZP_PAGE = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    addr_mode_sequencer_if.slave  bus,
    output seq_state_t            state_dbg
);

    seq_state_t  state;
    seq_state_t  next_state;

    // Request captured at start
    logic [2:0]  mode_q;
    logic [15:0] pc_q;
    logic [7:0]  x_q;
    logic [7:0]  y_q;

    // Working registers: address bytes, zero-page pointer, page-cross flag
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [7:0]  zp;
    logic        pc_flag;

    // Combinational output values
    logic        mem_rd_c;
    logic [15:0] mem_addr_c;
    logic        alu_sel_c;
    logic [1:0]  alu_op_c;
    logic [7:0]  alu_a_c;
    logic [7:0]  alu_b_c;
    logic [15:0] ea_c;
    logic        ea_valid_c;
    logic        page_cross_c;
    logic [1:0]  oper_len_c;

    logic [7:0]  zp_inc;
    logic [15:0] pc_inc;
    logic [7:0]  index_val;

    // Pointer high byte wraps inside the zero page; operand address wraps
    // across the full 16-bit space.
    assign zp_inc    = zp + 8'd1;
    assign pc_inc    = pc_q + 16'd1;
    assign index_val = index_used_x() ? x_q : y_q;

    function automatic logic index_used_x();
        return index_uses_x(mode_q);
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode; unused buses are driven to zero.
    always_comb begin
        next_state   = state;
        mem_rd_c     = 1'b0;
        mem_addr_c   = 16'h0000;
        alu_sel_c    = 1'b0;
        alu_op_c     = ALU_ADR0;
        alu_a_c      = 8'h00;
        alu_b_c      = 8'h00;
        ea_c         = 16'h0000;
        ea_valid_c   = 1'b0;
        page_cross_c = 1'b0;
        oper_len_c   = 2'd0;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    next_state = S_FETCH_LO;
                end
            end

            S_FETCH_LO: begin
                mem_rd_c   = 1'b1;
                mem_addr_c = pc_q;
                case (mode_q)
                    MODE_ZP:                        next_state = S_DONE;
                    MODE_ZPX, MODE_ZPY, MODE_INDX:  next_state = S_INDEX_LO;
                    MODE_ABS, MODE_ABSX, MODE_ABSY: next_state = S_FETCH_HI;
                    default:                        next_state = S_PTR_LO;
                endcase
            end

            S_FETCH_HI: begin
                mem_rd_c   = 1'b1;
                mem_addr_c = pc_inc;
                next_state = (mode_q == MODE_ABS) ? S_DONE : S_INDEX_LO;
            end

            S_INDEX_LO: begin
                alu_sel_c = 1'b1;
                alu_op_c  = ALU_ADR0;
                alu_a_c   = (mode_q == MODE_INDX) ? zp : lo;
                alu_b_c   = index_val;
                case (mode_q)
                    MODE_ZPX, MODE_ZPY: next_state = S_DONE;
                    MODE_INDX:          next_state = S_PTR_LO;
                    default:            next_state = S_INDEX_HI;
                endcase
            end

            // Always the cycle right after INDEX_LO: the unit's carry
            // register only holds the ADR0 carry for one cycle.
            S_INDEX_HI: begin
                alu_sel_c  = 1'b1;
                alu_op_c   = ALU_ADR1;
                alu_a_c    = 8'h00;
                alu_b_c    = hi;
                next_state = S_DONE;
            end

            S_PTR_LO: begin
                mem_rd_c   = 1'b1;
                mem_addr_c = {ZP_PAGE, zp};
                next_state = S_PTR_HI;
            end

            S_PTR_HI: begin
                mem_rd_c   = 1'b1;
                mem_addr_c = {ZP_PAGE, zp_inc};
                next_state = (mode_q == MODE_INDX) ? S_DONE : S_INDEX_LO;
            end

            S_DONE: begin
                ea_valid_c   = 1'b1;
                ea_c         = {hi, lo};
                page_cross_c = uses_carry(mode_q) & pc_flag;
                oper_len_c   = is_abs_mode(mode_q) ? 2'd2 : 2'd1;
                next_state   = S_IDLE;
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Datapath registers: request capture, fetched bytes and index results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= 3'd0;
            pc_q    <= 16'h0000;
            x_q     <= 8'h00;
            y_q     <= 8'h00;
            lo      <= 8'h00;
            hi      <= 8'h00;
            zp      <= 8'h00;
            pc_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mode_q  <= bus.mode;
                        pc_q    <= bus.pc;
                        x_q     <= bus.x;
                        y_q     <= bus.y;
                        lo      <= 8'h00;
                        // Plain zp goes straight to DONE, so the zero page
                        // must already be in the high byte.
                        hi      <= ZP_PAGE;
                        zp      <= 8'h00;
                        pc_flag <= 1'b0;
                    end
                end

                S_FETCH_LO: begin
                    lo <= bus.mem_data;
                    zp <= bus.mem_data;
                end

                S_FETCH_HI: begin
                    hi <= bus.mem_data;
                end

                S_INDEX_LO: begin
                    if (mode_q == MODE_INDX) begin
                        zp <= bus.alu_out;
                    end else if ((mode_q == MODE_ZPX) || (mode_q == MODE_ZPY)) begin
                        // Zero-page indexing wraps: carry is dropped.
                        lo <= bus.alu_out;
                        hi <= ZP_PAGE;
                    end else begin
                        lo      <= bus.alu_out;
                        pc_flag <= bus.alu_carry;
                    end
                end

                S_INDEX_HI: begin
                    hi <= bus.alu_out;
                end

                S_PTR_LO: begin
                    lo <= bus.mem_data;
                end

                S_PTR_HI: begin
                    hi <= bus.mem_data;
                end

                default: begin
                end
            endcase
        end
    end

    assign bus.mem_rd     = mem_rd_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.alu_sel    = alu_sel_c;
    assign bus.alu_opcode = alu_op_c;
    assign bus.alu_a      = alu_a_c;
    assign bus.alu_b      = alu_b_c;
    assign bus.ea         = ea_c;
    assign bus.ea_valid   = ea_valid_c;
    assign bus.page_cross = page_cross_c;
    assign bus.oper_len   = oper_len_c;
    assign bus.busy       = (state != S_IDLE);
    assign state_dbg      = state;

endmodule

// File: tb/tb_addr_mode_sequencer.sv
// Bench for addr_mode_sequencer: memory and arithmetic-unit models around
// the DUT, directed address-mode cases, reset/busy cases and random ops
// checked against an address-mode reference model.
module tb_addr_mode_sequencer;
  import addr_mode_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  addr_mode_sequencer_if bus();
  seq_state_t state_dbg;

  addr_mode_sequencer #(.ZP_PAGE(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- environment models ----------------
  logic [7:0] mem [0:65535];
  assign bus.mem_data = bus.mem_rd ? mem[bus.mem_addr] : 8'h00;

  // Arithmetic unit: ADR0 = a+b, ADR1 = a+b+carry of previous cycle.
  logic [8:0] alu_sum;
  logic       alu_c_q;
  always_comb begin
    alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b}
            + {8'd0, (bus.alu_opcode == ALU_ADR1) & alu_c_q};
  end
  assign bus.alu_out   = alu_sum[7:0];
  assign bus.alu_carry = alu_sum[8];
  always @(posedge clk) alu_c_q <= alu_sum[8];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Every cycle: unused buses must read zero.
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("unused_zero",
            {11'd0,
             (bus.mem_rd ? 16'h0 : bus.mem_addr),
             (bus.alu_sel ? 18'h0 : {bus.alu_opcode, bus.alu_a, bus.alu_b}),
             (bus.ea_valid ? 19'h0 : {bus.ea, bus.page_cross, bus.oper_len})},
            64'd0);
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] exp_q[$];
  logic [15:0] m_ea;
  logic        m_pc;
  logic [1:0]  m_len;
  int          m_lat;
  bit          m_adr1;

  task automatic model(input logic [2:0] md, input logic [15:0] p,
                       input logic [7:0] xi, input logic [7:0] yi);
    logic [7:0]  b0, b1, ptr, idx;
    logic [15:0] base;
    exp_q.delete();
    b0  = mem[p];
    b1  = mem[p + 16'd1];
    idx = (md == MODE_ZPY || md == MODE_ABSY || md == MODE_INDY) ? yi : xi;
    exp_q.push_back(p);
    m_pc   = 1'b0;
    m_adr1 = 1'b0;
    m_len  = (md == MODE_ABS || md == MODE_ABSX || md == MODE_ABSY) ? 2'd2 : 2'd1;
    case (md)
      MODE_ZP: begin
        m_ea = {8'h00, b0}; m_lat = 2;
      end
      MODE_ZPX, MODE_ZPY: begin
        m_ea = 16'((int'(b0) + int'(idx)) % 256); m_lat = 3;
      end
      MODE_ABS: begin
        exp_q.push_back(p + 16'd1);
        m_ea = {b1, b0}; m_lat = 3;
      end
      MODE_ABSX, MODE_ABSY: begin
        exp_q.push_back(p + 16'd1);
        base = {b1, b0};
        m_ea = 16'((int'(base) + int'(idx)) % 65536);
        m_pc = (int'(b0) + int'(idx)) > 255;
        m_lat = 5; m_adr1 = 1'b1;
      end
      MODE_INDX: begin
        ptr = 8'((int'(b0) + int'(idx)) % 256);
        exp_q.push_back({8'h00, ptr});
        exp_q.push_back({8'h00, 8'((int'(ptr) + 1) % 256)});
        m_ea = {mem[{8'h00, 8'((int'(ptr) + 1) % 256)}], mem[{8'h00, ptr}]};
        m_lat = 5;
      end
      default: begin
        exp_q.push_back({8'h00, b0});
        exp_q.push_back({8'h00, 8'((int'(b0) + 1) % 256)});
        base = {mem[{8'h00, 8'((int'(b0) + 1) % 256)}], mem[{8'h00, b0}]};
        m_ea = 16'((int'(base) + int'(idx)) % 65536);
        m_pc = (int'(base[7:0]) + int'(idx)) > 255;
        m_lat = 6; m_adr1 = 1'b1;
      end
    endcase
  endtask

  // ---------------- driver ----------------
  logic [15:0] last_ea;
  logic        last_pc;

  task automatic run_op(input logic [2:0] md, input logic [15:0] p,
                        input logic [7:0] xi, input logic [7:0] yi, input bit poke);
    int n, a1, extra, k;
    bit got;
    logic [15:0] rd_q[$];
    logic [63:0] rd_val;
    model(md, p, xi, yi);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = md; bus.pc = p; bus.x = xi; bus.y = yi;
    n = 0; a1 = -1; got = 1'b0;
    last_ea = 16'h0; last_pc = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      if (bus.mem_rd) rd_q.push_back(bus.mem_addr);
      if (bus.alu_sel && bus.alu_opcode == ALU_ADR1) a1 = n;
      if (bus.ea_valid) begin
        got = 1'b1;
        last_ea = bus.ea; last_pc = bus.page_cross;
        check("ea", bus.ea, m_ea);
        check("page_cross", bus.page_cross, m_pc);
        check("oper_len", bus.oper_len, m_len);
      end
      // Scramble the request once taken; poke start while busy if asked.
      bus.start = 1'b0;
      bus.mode = 3'($urandom_range(0, 7)); bus.pc = 16'($urandom);
      bus.x = 8'($urandom); bus.y = 8'($urandom);
      if (poke && n == 2) bus.start = 1'b1;
    end
    bus.start = 1'b0;
    check("ea_valid_seen", got, 1'b1);
    check("latency", n, m_lat);
    check("rd_count", rd_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      rd_val = (i < rd_q.size()) ? 64'(rd_q[i]) : 64'hdead_0000;
      check("rd_addr", rd_val, exp_q[i]);
    end
    check("adr1_cycle", a1, m_adr1 ? m_lat - 1 : -1);
    if (poke) begin
      extra = 0;
      for (k = 0; k < 8; k++) begin
        @(negedge clk);
        if (bus.ea_valid) extra++;
      end
      check("no_extra_valid", extra, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    bus.start = 1'b0; bus.mode = 3'd0; bus.pc = 16'h0; bus.x = 8'h0; bus.y = 8'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {bus.mem_rd, bus.mem_addr, bus.alu_sel, bus.alu_opcode, bus.alu_a, bus.alu_b,
           bus.ea, bus.ea_valid, bus.page_cross, bus.oper_len, bus.busy}, 64'd0);
    check("reset_state", state_dbg, S_IDLE);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // ABSX with page cross
    mem[16'h0200] = 8'hF0; mem[16'h0201] = 8'h12;
    run_op(MODE_ABSX, 16'h0200, 8'h20, 8'h00, 1'b0);
    check("absx_ea_const", last_ea, 16'h1310);
    check("absx_pc_const", last_pc, 1'b1);

    // ZPX wraps in page zero
    mem[16'h0300] = 8'hF0;
    run_op(MODE_ZPX, 16'h0300, 8'h20, 8'h00, 1'b0);
    check("zpx_ea_const", last_ea, 16'h0010);

    // INDY with pointer wrap FF->00
    mem[16'h0400] = 8'hFF; mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
    run_op(MODE_INDY, 16'h0400, 8'h00, 8'h10, 1'b0);
    check("indy_ea_const", last_ea, 16'h1244);

    // INDX
    mem[16'h0500] = 8'h80; mem[16'h0085] = 8'h00; mem[16'h0086] = 8'h30;
    run_op(MODE_INDX, 16'h0500, 8'h05, 8'h00, 1'b0);
    check("indx_ea_const", last_ea, 16'h3000);

    // ABS with PC wrap FFFF->0000
    mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
    run_op(MODE_ABS, 16'hFFFF, 8'h00, 8'h00, 1'b0);
    check("abs_ea_const", last_ea, 16'h1234);

    // Start pulsed while busy must be ignored
    run_op(MODE_INDY, 16'h0600, 8'h00, 8'h33, 1'b1);

    // Reset in the middle of an ABSX sequence
    @(negedge clk);
    bus.start = 1'b1; bus.mode = MODE_ABSX; bus.pc = 16'h0200; bus.x = 8'h20;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    while (state_dbg != S_INDEX_LO && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("reach_index_lo", state_dbg, S_INDEX_LO);
    rst_n = 1'b0;
    #1;
    check("midop_rst_outputs",
          {bus.mem_rd, bus.mem_addr, bus.alu_sel, bus.alu_opcode, bus.alu_a, bus.alu_b,
           bus.ea, bus.ea_valid, bus.page_cross, bus.oper_len, bus.busy}, 64'd0);
    check("midop_rst_state", state_dbg, S_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.ea_valid) cnt++;
    end
    check("no_valid_after_rst", cnt, 0);

    // Random operations
    for (int t = 0; t < 200; t++) begin
      logic [2:0] md;
      md = 3'($urandom_range(0, 7));
      run_op(md, 16'($urandom), 8'($urandom), 8'($urandom),
             (md == MODE_INDY) && ($urandom_range(0, 1) == 1));
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/addr_mode_sequencer.md
Name: addr_mode_sequencer

Overview:
Operand-fetch and effective-address sequencer that sits directly upstream of the arithmetic unit. It covers the 6502 addressing modes zp, zp,X, zp,Y, abs, abs,X, abs,Y, (zp,X) and (zp),Y.
- Fetches operand and pointer bytes over the memory read port.
- Borrows the arithmetic unit for indexing: ADR0 adds the index to the low byte; ADR1 adds the registered carry to the high byte.
- Delivers a 16-bit effective address plus a page-cross indication to the execute control.

Parameters:
ZP_PAGE, 8'h00, high byte used for zero-page modes and for zero-page pointer fetches.

Ports:
clk  in  1  system clock, all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin sequence; accepted only when busy=0
mode  in  3  0=ZP 1=ZPX 2=ZPY 3=ABS 4=ABSX 5=ABSY 6=INDX 7=INDY
pc  in  16  address of first operand byte, sampled at start
x  in  8  X index, sampled at start
y  in  8  Y index, sampled at start
mem_rd  out  1  read strobe
mem_addr  out  16  read address
mem_data  in  8  read data, valid in the same cycle as mem_rd, captured at the cycle-ending edge
alu_sel  out  1  sequencer owns the arithmetic unit this cycle; top-level mux selects these ALU inputs
alu_opcode  out  2  2'b00=ADR0 or 2'b01=ADR1; 2'b00 when alu_sel=0
alu_a  out  8  ALU operand A
alu_b  out  8  ALU operand B
alu_out  in  8  ALU result
alu_carry  in  1  ALU flags_out[0]
ea  out  16  effective address, valid while ea_valid=1
ea_valid  out  1  one-cycle completion pulse
page_cross  out  1  carry out of ADR0 for ABSX/ABSY/INDY; 0 for other modes; valid with ea_valid
oper_len  out  2  operand byte count: 1 for zp/ind modes, 2 for abs modes; valid with ea_valid
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, immediate while rst_n=0):
  - state=IDLE.
  - All outputs 0.
  - Internal regs mode_q, pc_q, x_q, y_q, lo, hi, zp, pc_flag all 0.
- States: IDLE, FETCH_LO, FETCH_HI, INDEX_LO, INDEX_HI, PTR_LO, PTR_HI, DONE.
- IDLE: if start, latch mode/pc/x/y and go to FETCH_LO. start while busy=1 is ignored, never queued.
- FETCH_LO: mem_rd=1, mem_addr=pc_q; lo<=mem_data, zp<=mem_data. Next state by mode:
  - ZP -> DONE
  - ZPX, ZPY, INDX -> INDEX_LO
  - ABS, ABSX, ABSY -> FETCH_HI
  - INDY -> PTR_LO
- FETCH_HI: mem_addr=pc_q+1 (16-bit wrap, FFFF->0000); hi<=mem_data. ABS -> DONE; ABSX, ABSY -> INDEX_LO.
- INDEX_LO: alu_sel=1, ADR0.
  - alu_a=lo, or zp for INDX.
  - alu_b=X for ZPX, ABSX, INDX; Y for ZPY, ABSY, INDY.
  - ZPX, ZPY: lo<=alu_out, hi<=ZP_PAGE, carry discarded -> DONE (zero-page wrap).
  - INDX: zp<=alu_out -> PTR_LO.
  - ABSX, ABSY, INDY: lo<=alu_out, pc_flag<=alu_carry -> INDEX_HI.
- INDEX_HI: alu_sel=1, ADR1, alu_b=hi, alu_a=0; hi<=alu_out -> DONE.
  - Must occur in the cycle immediately after INDEX_LO, because the ALU's carry register holds only one cycle. No stall is permitted between these two states.
- PTR_LO: mem_addr={ZP_PAGE,zp}; lo<=mem_data -> PTR_HI.
- PTR_HI: mem_addr={ZP_PAGE,zp+1}, 8-bit wrap (FF->00); hi<=mem_data.
  - INDX -> DONE.
  - INDY -> INDEX_LO.
- DONE: ea_valid=1, ea={hi,lo}, page_cross=pc_flag (0 for modes without carry use), oper_len per mode -> IDLE. A new start is accepted only from IDLE, i.e. the cycle after DONE.
- Latency, start cycle to ea_valid cycle: ZP 2; ZPX, ZPY, ABS 3; ABSX, ABSY, INDX 5; INDY 6. ABSX/ABSY/INDY always run ADR1, so latency does not depend on page_cross.
- Output rules:
  - mem_rd=1 only in FETCH_LO, FETCH_HI, PTR_LO, PTR_HI.
  - mem_addr=0 and alu_a/alu_b=0 when unused.
  - ea is held 0 except in DONE.

Decomposition:
- Shared package holds:
  - the addressing-mode encoding constants (3-bit);
  - the ALU opcode constants ADR0=2'b00, ADR1=2'b01, ADC=2'b10, LD=2'b11, shared with the arithmetic unit;
  - the state enumeration.
- Single module, no sub-module. The next-state logic is one combinational block and the datapath registers are one sequential block.

Test Plan:
- ABSX: pc=0x0200, mem[0200]=F0, mem[0201]=12, X=20 -> ea=0x1310, page_cross=1, oper_len=2, ea_valid 5 cycles after start, ADR0 and ADR1 in consecutive cycles.
- ZPX wrap: mem[pc]=F0, X=20 -> ea=0x0010, page_cross=0, oper_len=1, latency 3.
- INDY with pointer wrap: mem[pc]=FF, mem[00FF]=34, mem[0000]=12, Y=10 -> reads 00FF then 0000, ea=0x1244, page_cross=0, latency 6.
- INDX: mem[pc]=80, X=05, mem[0085]=00, mem[0086]=30 -> ea=0x3000, page_cross=0, latency 5.
- ABS at PC wrap: pc=FFFF, mem[FFFF]=34, mem[0000]=12 -> ea=0x1234, latency 3.
- Reset mid-op and start while busy:
  - rst_n low during INDEX_LO of an ABSX sequence -> all outputs 0 immediately, state IDLE, no ea_valid after release.
  - start pulsed while busy -> ignored, no second ea_valid.
